// File: rtl/vmem_write_scheduler_pkg.sv
// Shared definitions for the video-memory write scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vmem_write_scheduler_pkg;

  // Default cell-coordinate and colour widths (32x32 grid, 3-bit RGB).
  localparam int COORD_W_DEF = 5;
  localparam int COLOR_W_DEF = 3;

  // Scheduler states. ST_WAIT_VB is reachable only in the vblank-gated build.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_WAIT_VB = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/vmem_write_scheduler_rect_scan_counter.sv
// Row-major inclusive scan over a rectangle of cells, one cell per step.
// Latency: x/y/last valid the cycle after load; each step advances one cell.
// Backpressure: step is ignored once the last cell is reached, so counters never wrap.
// Ports: i_clk, i_rst (sync, active-high), i_load (latch bounds, x=X0, y=Y0),
//        i_step (advance), i_x0/i_x1/i_y0/i_y1 bounds, o_x/o_y current cell, o_last.
module vmem_write_scheduler_rect_scan_counter #(
  parameter int COORD_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_y1,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last
);

  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_x1;
  logic [COORD_W-1:0] r_y1;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_x  <= '0;
      r_y  <= '0;
    end else if (i_load) begin
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
      r_x  <= i_x0;
      r_y  <= i_y0;
    end else if (i_step && !o_last) begin
      // Holding at the last cell keeps X1=31/Y1=31 from rolling over to 0.
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_x1) && (r_y == r_y1);

endmodule

// File: rtl/vmem_write_scheduler.sv
// Sole owner of the video-memory write port: CPU writes vs. rectangle-fill engine.
// Latency: CPU write at t on outputs at t+1; first fill write at t+2 after start at t.
// Backpressure: CPU never stalls; a CPU write holds the fill on the same cell for that cycle.
// Ports: i_clock, i_reset (sync, active-high); i_cpu_write/addr/color CPU request;
//        i_fill_start, i_fill_x0/x1/y0/y1 (inclusive), i_fill_color, i_fill_abort, i_vblank;
//        o_write_enable/addr/data to video memory; o_busy, o_done, o_error status.
// Build option: VMEM_VBLANK_ONLY_EN gates fill writes to i_vblank=1 (adds ST_WAIT_VB).
module vmem_write_scheduler
  import vmem_write_scheduler_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cpu_write,
  input  logic [2*COORD_W-1:0] i_cpu_addr,
  input  logic [COLOR_W-1:0]   i_cpu_color,
  input  logic                 i_fill_start,
  input  logic [COORD_W-1:0]   i_fill_x0,
  input  logic [COORD_W-1:0]   i_fill_x1,
  input  logic [COORD_W-1:0]   i_fill_y0,
  input  logic [COORD_W-1:0]   i_fill_y1,
  input  logic [COLOR_W-1:0]   i_fill_color,
  input  logic                 i_fill_abort,
  input  logic                 i_vblank,
  output logic                 o_write_enable,
  output logic [2*COORD_W-1:0] o_write_addr,
  output logic [COLOR_W-1:0]   o_write_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_load;
  logic                 w_fill_wr;
  logic                 w_bad;
  logic                 w_last;
  logic [COORD_W-1:0]   w_x;
  logic [COORD_W-1:0]   w_y;
  logic [COLOR_W-1:0]   r_color;
  logic                 r_bad;
  logic                 r_we;
  logic [2*COORD_W-1:0] r_addr;
  logic [COLOR_W-1:0]   r_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  assign w_bad = (i_fill_x0 > i_fill_x1) || (i_fill_y0 > i_fill_y1);

`ifndef VMEM_VBLANK_ONLY_EN
  logic w_unused_vblank;
  assign w_unused_vblank = i_vblank;
`endif

  vmem_write_scheduler_rect_scan_counter #(.COORD_W(COORD_W)) u_scan (
    .i_clk  (i_clock),
    .i_rst  (i_reset),
    .i_load (w_load),
    .i_step (w_fill_wr),
    .i_x0   (i_fill_x0),
    .i_x1   (i_fill_x1),
    .i_y0   (i_fill_y0),
    .i_y1   (i_fill_y1),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_fill_wr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Abort has no meaning here, so a start alongside it is honoured.
        if (i_fill_start) begin
          w_load = 1'b1;
          w_next = w_bad ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (i_fill_abort) begin
          w_next = ST_IDLE;
`ifdef VMEM_VBLANK_ONLY_EN
        end else if (!i_vblank) begin
          w_next = ST_WAIT_VB;
`endif
        end else if (!i_cpu_write) begin
          w_fill_wr = 1'b1;
          if (w_last) begin
            w_next = ST_DONE;
          end
        end
      end
`ifdef VMEM_VBLANK_ONLY_EN
      ST_WAIT_VB: begin
        if (i_fill_abort) begin
          w_next = ST_IDLE;
        end else if (i_vblank) begin
          w_next = ST_FILL;
        end
      end
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_color <= '0;
      r_bad   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      // Status lags the state by one cycle, like every other output.
      r_busy  <= (r_state != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
      r_error <= (r_state == ST_DONE) && r_bad;
      if (w_load) begin
        r_color <= i_fill_color;
        r_bad   <= w_bad;
      end
      r_we <= i_cpu_write || w_fill_wr;
      if (i_cpu_write) begin
        r_addr <= i_cpu_addr;
        r_data <= i_cpu_color;
      end else if (w_fill_wr) begin
        r_addr <= {w_y, w_x};
        r_data <= r_color;
      end
    end
  end

  assign o_write_enable = r_we;
  assign o_write_addr   = r_addr;
  assign o_write_data   = r_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule
